// File: rtl/a_74hc193_updown_pkg.sv
// Shared types and defaults for the 74HC193-style up/down counter family.
package a74hc_pkg;

  localparam int A74HC_WIDTH = 4;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

endpackage

// File: rtl/a_74hc193_updown_if.sv
// Control/data bundle of one counter stage; master drives requests, slave is the counter.
interface a_74hc193_updown_if #(
  parameter int WIDTH = a74hc_pkg::A74HC_WIDTH
);
  logic             load;
  logic [WIDTH-1:0] D;
  logic             cnt_en;
  logic             up;
  logic             dn;
  logic [WIDTH-1:0] Q;
  logic             co;
  logic             bo;

  modport master (
    output load, D, cnt_en, up, dn,
    input  Q, co, bo
  );

  modport slave (
    input  load, D, cnt_en, up, dn,
    output Q, co, bo
  );
endinterface

// File: rtl/a_74hc193_updown_addsub.sv
// WIDTH-bit increment/decrement by one; the extra arithmetic bit is carry (up) or borrow (down).
module a_74hc_addsub
  import a74hc_pkg::*;
#(
  parameter int WIDTH = A74HC_WIDTH
) (
  input  logic [WIDTH-1:0] operand_i,
  input  dir_t             dir_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cb_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, operand_i};
    case (dir_i)
      DIR_UP:   sum = {1'b0, operand_i} + (WIDTH+1)'(1);
      DIR_DOWN: sum = {1'b0, operand_i} - (WIDTH+1)'(1);
      default:  sum = {1'b0, operand_i};
    endcase
  end

  assign result_o = sum[WIDTH-1:0];
  assign cb_o     = sum[WIDTH];

endmodule

// File: rtl/a_74hc193_updown.sv
// Synchronous up/down counter with parallel load and cascadable carry/borrow.
// Define A74HC193_SATURATE_EN to saturate at the terminal counts instead of wrapping.
module a_74hc193_updown
  import a74hc_pkg::*;
#(
  parameter int WIDTH = A74HC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  a_74hc193_updown_if.slave   bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] step;
  logic             cb;
  dir_t             dir;

  always_comb begin
    dir = DIR_HOLD;
    if (bus.cnt_en && bus.up && !bus.dn) begin
      dir = DIR_UP;
    end else if (bus.cnt_en && bus.dn && !bus.up) begin
      dir = DIR_DOWN;
    end
  end

  a_74hc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .operand_i (q_q),
    .dir_i     (dir),
    .result_o  (step),
    .cb_o      (cb)
  );

  // The carry/borrow bit is set exactly when a step would leave the range,
  // i.e. at the terminal count for the active direction.
  always_comb begin
    q_d = q_q;
    if (bus.load) begin
      q_d = bus.D;
    end else if (dir != DIR_HOLD) begin
`ifdef A74HC193_SATURATE_EN
      if (!cb) begin
        q_d = step;
      end
`else
      q_d = step;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.Q  = q_q;
  assign bus.co = (dir == DIR_UP)   && cb;
  assign bus.bo = (dir == DIR_DOWN) && cb;

endmodule

// File: tb/tb_a_74hc193_updown.sv
// Bench for a_74hc193_updown: directed scenarios, a two-stage cascade and random traffic vs a model.
module tb_a_74hc193_updown;
  import a74hc_pkg::*;

  localparam int W = 4;
`ifdef A74HC193_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   q_m;

  always #5 clk = ~clk;

  a_74hc193_updown_if #(.WIDTH(W)) lo_if ();
  a_74hc193_updown_if #(.WIDTH(W)) hi_if ();

  assign hi_if.cnt_en = lo_if.co | lo_if.bo;
  assign hi_if.up     = lo_if.up;
  assign hi_if.dn     = lo_if.dn;

  a_74hc193_updown #(.WIDTH(W)) u_lo (.clk(clk), .rst(rst), .bus(lo_if.slave));
  a_74hc193_updown #(.WIDTH(W)) u_hi (.clk(clk), .rst(rst), .bus(hi_if.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input logic [W-1:0] d,
                       input logic en, input logic u, input logic dv);
    @(negedge clk);
    rst          = r;
    lo_if.load   = ld;
    lo_if.D      = d;
    lo_if.cnt_en = en;
    lo_if.up     = u;
    lo_if.dn     = dv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic r, ld, en, u, dv;
    logic [W-1:0] d;
    int   exp_co, exp_bo;

    rst = 1'b1;
    lo_if.load = 1'b0; lo_if.D = '0; lo_if.cnt_en = 1'b0; lo_if.up = 1'b0; lo_if.dn = 1'b0;
    hi_if.load = 1'b0; hi_if.D = '0;

    // Reset beats load
    drive(1, 1, 4'hA, 0, 0, 0);
    tick();
    check("reset_q", lo_if.Q, 0);
    drive(0, 0, 4'h0, 0, 0, 0);
    check("reset_co", lo_if.co, 0);
    check("reset_bo", lo_if.bo, 0);
    drive(0, 0, 4'h0, 1, 0, 1);
    check("reset_bo_dn", lo_if.bo, 1);

    // Up wrap
    drive(0, 1, 4'hE, 0, 0, 0);
    tick();
    check("upw_load", lo_if.Q, 4'hE);
    drive(0, 0, 4'h0, 1, 1, 0);
    check("upw_co0", lo_if.co, 0);
    tick();
    check("upw_q1", lo_if.Q, 4'hF);
    check("upw_co1", lo_if.co, 1);
    tick();
    check("upw_q2", lo_if.Q, SAT ? 4'hF : 4'h0);
    check("upw_co2", lo_if.co, SAT ? 1 : 0);
    tick();
    check("upw_q3", lo_if.Q, SAT ? 4'hF : 4'h1);

    // Down wrap
    drive(0, 1, 4'h1, 0, 0, 0);
    tick();
    check("dnw_load", lo_if.Q, 4'h1);
    drive(0, 0, 4'h0, 1, 0, 1);
    check("dnw_bo0", lo_if.bo, 0);
    tick();
    check("dnw_q1", lo_if.Q, 4'h0);
    check("dnw_bo1", lo_if.bo, 1);
    tick();
    check("dnw_q2", lo_if.Q, SAT ? 4'h0 : 4'hF);
    check("dnw_bo2", lo_if.bo, SAT ? 1 : 0);
    tick();
    check("dnw_q3", lo_if.Q, SAT ? 4'h0 : 4'hE);

    // Hold cases
    drive(0, 1, 4'h5, 0, 0, 0);
    tick();
    drive(0, 0, 4'h0, 1, 1, 1);
    check("hold_both_co", lo_if.co, 0);
    check("hold_both_bo", lo_if.bo, 0);
    tick();
    check("hold_both_q", lo_if.Q, 4'h5);
    drive(0, 0, 4'h0, 0, 1, 0);
    tick();
    check("hold_en0_q", lo_if.Q, 4'h5);
    check("hold_en0_co", lo_if.co, 0);
    check("hold_en0_bo", lo_if.bo, 0);

    // Load wins over a terminal-count step
    drive(0, 1, 4'hF, 0, 0, 0);
    tick();
    drive(0, 1, 4'h3, 1, 1, 0);
    check("ldpri_co", lo_if.co, 1);
    tick();
    check("ldpri_q", lo_if.Q, 4'h3);

    // Reset mid-count
    drive(1, 0, 4'h0, 1, 1, 0);
    tick();
    check("rst_mid_q", lo_if.Q, 0);

    // Cascade: 8-bit counter from two stages
    @(negedge clk);
    rst = 1'b0;
    lo_if.load = 1'b1; lo_if.D = 4'hF; hi_if.load = 1'b1; hi_if.D = 4'h0;
    lo_if.cnt_en = 1'b0; lo_if.up = 1'b0; lo_if.dn = 1'b0;
    tick();
    @(negedge clk);
    lo_if.load = 1'b0; hi_if.load = 1'b0; lo_if.cnt_en = 1'b1; lo_if.up = 1'b1;
    tick();
    check("casc_up", {hi_if.Q, lo_if.Q}, SAT ? 8'h1F : 8'h10);
    @(negedge clk);
    lo_if.load = 1'b1; lo_if.D = 4'h0; hi_if.load = 1'b1; hi_if.D = 4'h0;
    lo_if.cnt_en = 1'b0; lo_if.up = 1'b0;
    tick();
    @(negedge clk);
    lo_if.load = 1'b0; hi_if.load = 1'b0; lo_if.cnt_en = 1'b1; lo_if.dn = 1'b1;
    tick();
    check("casc_dn", {hi_if.Q, lo_if.Q}, SAT ? 8'h00 : 8'hFF);

    // Random traffic against an arithmetic model of the count
    drive(1, 0, 4'h0, 0, 0, 0);
    tick();
    q_m = 0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 29) == 0);
      ld = ($urandom_range(0, 7) == 0);
      d  = W'($urandom);
      en = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom);
      dv = 1'($urandom);
      // bias toward terminal counts so wrap/saturate paths get exercised
      if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? 4'hF : 4'h0;
      drive(r, ld, d, en, u, dv);
      exp_co = (en && u && !dv && q_m == 15) ? 1 : 0;
      exp_bo = (en && dv && !u && q_m == 0) ? 1 : 0;
      check("rnd_co", lo_if.co, exp_co);
      check("rnd_bo", lo_if.bo, exp_bo);
      tick();
      if (r) q_m = 0;
      else if (ld) q_m = d;
      else if (en && u && !dv) q_m = SAT ? ((q_m == 15) ? 15 : q_m + 1) : (q_m + 1) % 16;
      else if (en && dv && !u) q_m = SAT ? ((q_m == 0) ? 0 : q_m - 1) : (q_m + 15) % 16;
      check("rnd_q", lo_if.Q, q_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a_74hc193_updown.md
# a_74hc193_updown

Synchronous up/down binary counter with parallel load and cascadable carry/borrow terminal-count outputs, modelled on the 74HC193 but fully synchronous. It is the count-down counterpart to the team's 4-bit ripple adder and 74HC161 up-counter models. Its carry/borrow outputs drive the enables of a higher-order stage to build wider counters. It feeds the timer/prescaler chains in the discrete-logic library.

## Interface
- WIDTH, 4: counter width in bits (≥2).
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high; clears counter.
- load  in  1  parallel load of D (synchronous).
- D  in  WIDTH  parallel load value.
- cnt_en  in  1  cascade enable; counting happens only when high.
- up  in  1  count-up request.
- dn  in  1  count-down request.
- Q  out  WIDTH  registered count.
- co  out  1  carry: terminal count while counting up (combinational).
- bo  out  1  borrow: terminal count while counting down (combinational).

## Operation
- Priority per rising edge: rst > load > count > hold.
- rst=1: Q←0. load and count ignored.
- load=1 (rst=0): Q←D, regardless of cnt_en/up/dn.
- Count step when cnt_en=1 and exactly one of up/dn is high:
  - up: Q←Q+1 mod 2^WIDTH.
  - dn: Q←Q−1 mod 2^WIDTH.
- up=dn=1, up=dn=0 or cnt_en=0: hold.
- Arithmetic is WIDTH+1 bits wide. The extra bit is the carry/borrow out. It is not stored; Q takes the low WIDTH bits.
- co = cnt_en & up & ~dn & (Q == 2^WIDTH−1).
- bo = cnt_en & dn & ~up & (Q == 0).
- co and bo are never both high.
- Cascading: the upper stage's cnt_en is tied to the lower stage's co|bo, and up/dn are shared. The upper stage then steps on the same edge at which the lower stage wraps.
- Mode state: the block has an implicit 3-state direction decode {HOLD, UP, DOWN} from cnt_en/up/dn. It is combinational; Q is the only stored state.

## Timing
- Reset values: Q=0, so co=0 and bo=0 unless a count is requested.
- With Q=0 and cnt_en=1, dn=1, up=0, bo=1 immediately after reset.
- Latency: Q updates 1 cycle after the requesting inputs are sampled. co/bo are zero-latency functions of the current Q and the inputs.
- Wrap-around:
  - UP from 2^WIDTH−1 with co=1 → next Q=0.
  - DOWN from 0 with bo=1 → next Q=2^WIDTH−1.
- load coincident with a terminal count: load wins and Q←D. co/bo still reflect pre-edge Q, so a cascaded upper stage steps on that edge.
- rst asserted mid-count: Q=0 on that edge. No partial step.

## Configuration
- A74HC193_SATURATE_EN:
  - Defined: counting saturates. UP at 2^WIDTH−1 holds, DOWN at 0 holds. co/bo still assert at the terminal count, so cascades still work.
  - Undefined (default): modular wrap as described above.
- Load and reset behaviour are identical in both builds.

## Structure
- Shared package a74hc_pkg holds:
  - default width constant A74HC_WIDTH=4
  - enum dir_t {DIR_HOLD, DIR_UP, DIR_DOWN}
- One sub-module, a_74hc_addsub: WIDTH-bit add/subtract-by-one step.
  - Inputs: operand, direction.
  - Outputs: WIDTH result and the carry/borrow bit.
  - The top level instantiates it once and registers its result.

## Test plan
- Reset: rst=1 with load=1, D=4'hA → Q=0, co=0, bo=0 next cycle.
- Up wrap: load D=4'hE, then cnt_en=1, up=1 for 3 cycles → Q=F (co=1), 0 (co=0), 1.
- Down wrap: load D=4'h1, then cnt_en=1, dn=1 for 3 cycles → Q=0 (bo=1), F, E. With A74HC193_SATURATE_EN: Q=0, 0, 0 with bo held at 1.
- Hold cases: Q=5 with up=dn=1, then cnt_en=0 with up=1 → Q stays 5, co=bo=0.
- Load priority: Q=F, up=1, cnt_en=1, load=1, D=3 → co=1 during the cycle, Q=3 next.
- Cascade: two WIDTH=4 stages form 8 bits. Load 8'h0F, up one step → 8'h10; load 8'h00, dn one step → 8'hFF.
